// File: rtl/player_anim_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : player_anim_pkg
//  Description : Shared types and constants for the player sprite animation
//                controller (state encoding, image bank numbers, bank select).
//  Revision    : 1.0 - initial release
// ============================================================================
package player_anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        JUMP = 2'd2,
        HIT  = 2'd3
    } anim_state_t;

    localparam logic [2:0] FRAME_IDLE   = 3'd0;
    localparam logic [2:0] FRAME_WALK_A = 3'd1;
    localparam logic [2:0] FRAME_WALK_B = 3'd2;
    localparam logic [2:0] FRAME_JUMP   = 3'd3;
    localparam logic [2:0] FRAME_HIT    = 3'd4;

    // Image bank shown for a given state; walk alternates between two images.
    function automatic logic [2:0] frame_for(input anim_state_t s, input logic walk_phase);
        logic [2:0] sel;
        case (s)
            IDLE:    sel = FRAME_IDLE;
            WALK:    sel = walk_phase ? FRAME_WALK_B : FRAME_WALK_A;
            JUMP:    sel = FRAME_JUMP;
            HIT:     sel = FRAME_HIT;
            default: sel = FRAME_IDLE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_anim_ctrl_frame_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_counter
//  Description : Modulo-MAX frame counter. Advances on its tick input, has a
//                synchronous clear with priority, and flags the wrap tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic clr,
    output logic wrap
);
    localparam int           W    = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over advance; the count returns to zero after the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (startOfFrame) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously by the system reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign wrap = (cnt_q == LAST) & startOfFrame;

endmodule
`default_nettype wire

// File: rtl/player_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : player_anim_ctrl
//  Description : Frame-synchronous animation controller for the 32x32 player
//                sprite: image select, facing direction, post-hit blink and
//                drawingRequest gating. All state moves on startOfFrame only.
//  Config      : PLAYER_MIRROR_EN - when defined, mirror offsetX while facing
//                left; otherwise offsetX passes through unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_anim_ctrl
    import player_anim_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 8,
    parameter int JUMP_FRAMES     = 30,
    parameter int HIT_FRAMES      = 60,
    parameter int BLINK_HALF      = 4,
    parameter int OBJECT_WIDTH_X  = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        moveLeft,
    input  logic        moveRight,
    input  logic        jumpReq,
    input  logic        hitEvent,
    input  logic [10:0] offsetX,
    input  logic        bmpDrawReq,
    output logic [10:0] offsetXOut,
    output logic [2:0]  frameSel,
    output logic        drawingRequest,
    output logic        invulnerable
);
    localparam logic [10:0] MIRROR_BASE = 11'(OBJECT_WIDTH_X - 1);

    anim_state_t state_q, state_d;
    logic [2:0]  frame_sel_q, frame_sel_d;
    logic        facing_left_q, facing_left_d;
    logic        visible_q, visible_d;
    logic        invulnerable_q, invulnerable_d;
    logic        hit_pend_q, hit_pend_d;
    logic        jump_pend_q, jump_pend_d;
    logic        walk_phase_q, walk_phase_d;

    logic        hit_now, jump_now, move_one;
    anim_state_t rest_state;
    logic        step_tick, step_clr, step_wrap;
    logic        jump_tick, jump_clr, jump_wrap;
    logic        hit_tick,  hit_clr,  hit_wrap;
    logic        blink_wrap;

    // A request pulse coinciding with startOfFrame counts for that boundary.
    assign hit_now    = hit_pend_q | hitEvent;
    assign jump_now   = jump_pend_q | jumpReq;
    assign move_one   = moveLeft ^ moveRight;
    assign rest_state = move_one ? WALK : IDLE;

    // Next-state selection with hit > jump > movement priority.
    always_comb begin
        state_d = state_q;
        if (startOfFrame) begin
            if (hit_now && (state_q != HIT)) begin
                state_d = HIT;
            end else if (jump_now && ((state_q == IDLE) || (state_q == WALK))) begin
                state_d = JUMP;
            end else begin
                case (state_q)
                    IDLE, WALK: state_d = rest_state;
                    JUMP:       if (jump_wrap) state_d = rest_state;
                    HIT:        if (hit_wrap)  state_d = IDLE;
                    default:    state_d = IDLE;
                endcase
            end
        end
    end

    // Counters advance while resident in their state and clear on entry.
    assign step_tick = startOfFrame & (state_q == WALK) & (state_d == WALK);
    assign step_clr  = startOfFrame & (state_q != WALK) & (state_d == WALK);
    assign jump_tick = startOfFrame & (state_q == JUMP);
    assign jump_clr  = startOfFrame & (state_q != JUMP) & (state_d == JUMP);
    assign hit_tick  = startOfFrame & (state_q == HIT);
    assign hit_clr   = startOfFrame & (state_q != HIT)  & (state_d == HIT);

    frame_tick_counter #(.MAX(FRAMES_PER_STEP)) u_step_cnt (
        .clk(clk), .resetN(resetN), .startOfFrame(step_tick), .clr(step_clr), .wrap(step_wrap)
    );
    frame_tick_counter #(.MAX(JUMP_FRAMES)) u_jump_cnt (
        .clk(clk), .resetN(resetN), .startOfFrame(jump_tick), .clr(jump_clr), .wrap(jump_wrap)
    );
    frame_tick_counter #(.MAX(HIT_FRAMES)) u_hit_cnt (
        .clk(clk), .resetN(resetN), .startOfFrame(hit_tick), .clr(hit_clr), .wrap(hit_wrap)
    );
    frame_tick_counter #(.MAX(BLINK_HALF)) u_blink_cnt (
        .clk(clk), .resetN(resetN), .startOfFrame(hit_tick), .clr(hit_clr), .wrap(blink_wrap)
    );

    // Per-frame bookkeeping: pending flags, facing, walk phase, blink, image select.
    always_comb begin
        hit_pend_d     = hit_pend_q | hitEvent;
        jump_pend_d    = jump_pend_q | jumpReq;
        facing_left_d  = facing_left_q;
        walk_phase_d   = walk_phase_q;
        visible_d      = visible_q;
        invulnerable_d = invulnerable_q;
        frame_sel_d    = frame_sel_q;
        if (startOfFrame) begin
            // Flags are always consumed here; those not acted on are discarded.
            hit_pend_d  = 1'b0;
            jump_pend_d = 1'b0;
            if (moveLeft && !moveRight)      facing_left_d = 1'b1;
            else if (moveRight && !moveLeft) facing_left_d = 1'b0;

            if (step_clr)       walk_phase_d = 1'b0;
            else if (step_wrap) walk_phase_d = ~walk_phase_q;

            if (hit_clr)                                  visible_d = 1'b0;
            else if ((state_q == HIT) && (state_d != HIT)) visible_d = 1'b1;
            else if (blink_wrap)                          visible_d = ~visible_q;

            invulnerable_d = (state_d == HIT);
            frame_sel_d    = frame_for(state_d, walk_phase_d);
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            frame_sel_q    <= FRAME_IDLE;
            facing_left_q  <= 1'b0;
            visible_q      <= 1'b1;
            invulnerable_q <= 1'b0;
            hit_pend_q     <= 1'b0;
            jump_pend_q    <= 1'b0;
            walk_phase_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_sel_q    <= frame_sel_d;
            facing_left_q  <= facing_left_d;
            visible_q      <= visible_d;
            invulnerable_q <= invulnerable_d;
            hit_pend_q     <= hit_pend_d;
            jump_pend_q    <= jump_pend_d;
            walk_phase_q   <= walk_phase_d;
        end
    end

    assign frameSel       = frame_sel_q;
    assign invulnerable   = invulnerable_q;
    assign drawingRequest = bmpDrawReq & visible_q;

`ifdef PLAYER_MIRROR_EN
    assign offsetXOut = facing_left_q ? (MIRROR_BASE - offsetX) : offsetX;
`else
    // Facing is still tracked so game logic behaves the same; it just has no pixel effect.
    logic [11:0] unused_mirror;
    assign unused_mirror = {facing_left_q, MIRROR_BASE};
    assign offsetXOut    = offsetX;
`endif

endmodule
`default_nettype wire
